// File: rtl/if_fetch_unit.sv
// if_fetch_unit: single-stage instruction fetch with a local loadable instruction memory.
// Optional sticky misaligned-redirect detection is enabled by defining IF_FETCH_MISALIGN_CHECK_EN.
module if_fetch_unit #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4096,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PC_SRC,
    input  logic [ADDR_W-1:0] BRANCH_TGT,
    input  logic              STALL,
    input  logic              IMEM_WE,
    input  logic [ADDR_W-1:0] IMEM_WADR,
    input  logic [DATA_W-1:0] IMEM_WDATA,
    output logic [DATA_W-1:0] CUR_INS,
    output logic [ADDR_W-1:0] NEXT_INS_ADR,
    output logic              INS_VALID
`ifdef IF_FETCH_MISALIGN_CHECK_EN
    ,
    output logic              MISALIGN
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   pc, pc_n;
    logic [DATA_W-1:0]   ins_n;
    logic [ADDR_W-1:0]   nadr_n;
    logic                valid_n;
    logic [ADDR_W-1:0]   pc_plus4;
    logic [ADDR_W-1:0]   tgt_aligned;
    logic                tgt_ok;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Address bits above the memory index and the byte offset are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{IMEM_WADR, BRANCH_TGT};

    assign rd_idx      = pc[IDX_W+1:2];
    assign wr_idx      = IMEM_WADR[IDX_W+1:2];
    assign rd_data     = mem[rd_idx];
    assign pc_plus4    = pc + ADDR_W'(4);
    assign tgt_aligned = {BRANCH_TGT[ADDR_W-1:2], 2'b00};

`ifdef IF_FETCH_MISALIGN_CHECK_EN
    logic misalign_n;
    assign tgt_ok = (BRANCH_TGT[1:0] == 2'b00);
`else
    assign tgt_ok = 1'b1;
`endif

    // Memory is not reset; the fetch path reads rd_data before this edge's write lands.
    always_ff @(posedge CLK) begin
        if (IMEM_WE) begin
            mem[wr_idx] <= IMEM_WDATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            CUR_INS      <= '0;
            NEXT_INS_ADR <= '0;
            INS_VALID    <= 1'b0;
`ifdef IF_FETCH_MISALIGN_CHECK_EN
            MISALIGN     <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            CUR_INS      <= ins_n;
            NEXT_INS_ADR <= nadr_n;
            INS_VALID    <= valid_n;
`ifdef IF_FETCH_MISALIGN_CHECK_EN
            MISALIGN     <= misalign_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ins_n   = CUR_INS;
        nadr_n  = NEXT_INS_ADR;
        valid_n = INS_VALID;
`ifdef IF_FETCH_MISALIGN_CHECK_EN
        misalign_n = MISALIGN;
`endif
        case (state)
            BOOT: begin
                state_n = RUN;
            end
            RUN: begin
                // A rejected (misaligned) redirect falls through to the sequential path.
                if (PC_SRC && tgt_ok) begin
                    pc_n    = tgt_aligned;
                    valid_n = 1'b0;
                end else if (!STALL) begin
                    ins_n   = rd_data;
                    nadr_n  = pc_plus4;
                    valid_n = 1'b1;
                    pc_n    = pc_plus4;
                end
`ifdef IF_FETCH_MISALIGN_CHECK_EN
                if (PC_SRC && !tgt_ok) begin
                    misalign_n = 1'b1;
                end
`endif
            end
            default: begin
                state_n = BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit (DEPTH=16): directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the fetch rules.
module tb_if_fetch_unit;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_tgt = '0;
    logic        stall = 1'b0;
    logic        imem_we = 1'b0;
    logic [31:0] imem_wadr = '0;
    logic [31:0] imem_wdata = '0;
    logic [31:0] cur_ins;
    logic [31:0] next_ins_adr;
    logic        ins_valid;
`ifdef IF_FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    if_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .PC_SRC      (pc_src),
        .BRANCH_TGT  (branch_tgt),
        .STALL       (stall),
        .IMEM_WE     (imem_we),
        .IMEM_WADR   (imem_wadr),
        .IMEM_WDATA  (imem_wdata),
        .CUR_INS     (cur_ins),
        .NEXT_INS_ADR(next_ins_adr),
        .INS_VALID   (ins_valid)
`ifdef IF_FETCH_MISALIGN_CHECK_EN
        ,
        .MISALIGN    (misalign)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_next = '0;
    logic        m_valid = 1'b0;
    logic        m_run = 1'b0;
    logic        m_mis = 1'b0;

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_ins"}, {32'h0, cur_ins}, {32'h0, m_ins});
        check({tag, "_nadr"}, {32'h0, next_ins_adr}, {32'h0, m_next});
        check({tag, "_valid"}, {63'h0, ins_valid}, {63'h0, m_valid});
`ifdef IF_FETCH_MISALIGN_CHECK_EN
        check({tag, "_mis"}, {63'h0, misalign}, {63'h0, m_mis});
`endif
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_ins = '0; m_next = '0; m_valid = 1'b0; m_run = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_edge(input logic src, input logic [31:0] tgt, input logic stl,
                              input logic we, input logic [31:0] wa, input logic [31:0] wd);
        logic [31:0] old_word;
        logic        take;
        old_word = m_mem[widx(m_pc)];
        take = src;
        if (!rst) begin
            if (!m_run) begin
                m_run = 1'b1;
            end else begin
`ifdef IF_FETCH_MISALIGN_CHECK_EN
                if (src && tgt[1:0] != 2'b00) begin
                    take = 1'b0;
                    m_mis = 1'b1;
                end
`endif
                if (take) begin
                    m_pc = tgt & 32'hFFFF_FFFC;
                    m_valid = 1'b0;
                end else if (!stl) begin
                    m_ins = old_word;
                    m_next = m_pc + 32'd4;
                    m_valid = 1'b1;
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        if (we) m_mem[widx(wa)] = wd;
    endtask

    task automatic step(input string tag, input logic src, input logic [31:0] tgt, input logic stl,
                        input logic we, input logic [31:0] wa, input logic [31:0] wd);
        pc_src = src; branch_tgt = tgt; stall = stl;
        imem_we = we; imem_wadr = wa; imem_wdata = wd;
        @(posedge clk);
        model_edge(src, tgt, stl, we, wa, wd);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [31:0] w;
        #1 rst = 1'b1;
        #1 check_outputs("reset");

        // Preload memory while held in reset
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 0) w = 32'hA;
            else if (i == 1) w = 32'hB;
            else if (i == 2) w = 32'hC;
            else w = $urandom;
            step("preload", 1'b0, 32'h0, 1'b0, 1'b1, 32'(i * 4), w);
        end

        // Boot: one BOOT cycle (with a loader write), then sequential fetch
        rst = 1'b0;
        step("boot", 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 32'h0D);
        step("fetch_a", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("fetch_b", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        step("resume_c", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Redirect with bubble
        step("redir_bubble", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        step("redir_fetch", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Redirect during stall takes priority
        step("stall_redir", 1'b1, 32'h8, 1'b1, 1'b0, 32'h0, 32'h0);
        step("stall_redir_f", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Memory index wrap
        step("wrap_redir", 1'b1, 32'h3C, 1'b0, 1'b0, 32'h0, 32'h0);
        step("wrap_m15", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("wrap_m0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // PC+4 wrap at top of address space
        step("top_redir", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0);
        step("top_fetch", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("top_wrap", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Read-before-write on the same word
        step("rbw_redir", 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
        step("rbw_old", 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF);
        step("rbw_redir2", 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0);
        step("rbw_new", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Misaligned redirect target
        step("mis_redir", 1'b1, 32'h42, 1'b0, 1'b0, 32'h0, 32'h0);
        step("mis_next", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("mis_next2", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
            step("rand", ($urandom_range(0, 5) == 0), t, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), $urandom, $urandom);
        end

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        step("rst_hold", 1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        step("rst_boot", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("rst_fetch0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("rst_fetch1", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
